// File: rtl/adc_bcd_conv_pkg.sv
// Shared BCD display definitions: digit geometry, converter state encoding,
// and the per-nibble double-dabble correction step.
package adc_bcd_conv_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4;

  typedef enum logic {
    ACCUM   = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  // Pre-shift correction so a nibble carries into the next decade after doubling.
  function automatic logic [BCD_W-1:0] add3_if_ge5(input logic [BCD_W-1:0] nibble);
    return (nibble >= BCD_W'(5)) ? nibble + BCD_W'(3) : nibble;
  endfunction

endpackage

// File: rtl/adc_bcd_conv_dd_engine.sv
// Iterative double-dabble core: one add-3/shift step per clock, DATA_W steps
// per conversion. done is high during the final step, with bcd already final.
module bcd_dd_engine
  import adc_bcd_conv_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DATA_W-1:0]           bin,
  output logic [BCD_DIGITS*BCD_W-1:0] bcd,
  output logic                        done,
  output logic                        busy
);

  localparam int BCD_TOT = BCD_DIGITS * BCD_W;
  localparam int IW      = $clog2(DATA_W + 1);

  logic               running;
  logic [IW-1:0]      iter;
  logic [DATA_W-1:0]  bin_sr;
  logic [BCD_TOT-1:0] scratch;
  logic [BCD_TOT-1:0] adj;
  logic [BCD_TOT-1:0] shifted;

  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[i*BCD_W +: BCD_W] = add3_if_ge5(scratch[i*BCD_W +: BCD_W]);
    end
  end

  assign shifted = BCD_TOT'({adj, bin_sr[DATA_W-1]});
  assign bcd     = shifted;
  assign done    = running && (iter == IW'(DATA_W - 1));
  assign busy    = running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      iter    <= '0;
      bin_sr  <= '0;
      scratch <= '0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= '0;
      bin_sr  <= bin;
      scratch <= '0;
    end else if (running) begin
      scratch <= shifted;
      bin_sr  <= bin_sr << 1;
      iter    <= iter + IW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_bcd_conv.sv
// ADC sample to 4-digit BCD converter: optional box-car averaging of
// 2^AVG_LOG2 samples, then a sequential double-dabble conversion.
module adc_bcd_conv
  import adc_bcd_conv_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic [BCD_W-1:0]  ones,
  output logic [BCD_W-1:0]  tens,
  output logic [BCD_W-1:0]  hundreds,
  output logic [BCD_W-1:0]  thousands,
  output logic              bcd_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int BCD_TOT = BCD_DIGITS * BCD_W;

  conv_state_t        state, state_next;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   sum;
  logic [DATA_W-1:0]  avg;
  logic               window_done;
  logic               eng_done;
  logic [BCD_TOT-1:0] eng_bcd;
  logic [BCD_TOT-1:0] digits;

  assign sum = acc + ACC_W'(data);
  assign avg = DATA_W'(sum >> AVG_LOG2);

  always_comb begin
    state_next  = state;
    window_done = 1'b0;
    case (state)
      ACCUM: begin
        window_done = data_valid && (cnt == CNT_W'((1 << AVG_LOG2) - 1));
        if (window_done) state_next = CONVERT;
      end
      CONVERT: begin
        if (eng_done) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // Samples arriving while converting are dropped without touching the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      overrun   <= 1'b0;
      bcd_valid <= 1'b0;
      digits    <= '0;
    end else begin
      overrun   <= data_valid && (state == CONVERT);
      bcd_valid <= eng_done;
      if (eng_done) digits <= eng_bcd;
      if (state == ACCUM && data_valid) begin
        if (window_done) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  bcd_dd_engine #(.DATA_W(DATA_W)) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .start (window_done),
    .bin   (avg),
    .bcd   (eng_bcd),
    .done  (eng_done),
    .busy  (busy)
  );

  assign ones      = digits[0*BCD_W +: BCD_W];
  assign tens      = digits[1*BCD_W +: BCD_W];
  assign hundreds  = digits[2*BCD_W +: BCD_W];
  assign thousands = digits[3*BCD_W +: BCD_W];

endmodule
